// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared AES geometry, GF(2^8) reduction constant, FSM encoding and the
// constant-multiply helpers used by the InvMixColumns datapath.
package inv_mix_columns_seq_pkg;

  localparam int AES_BYTE = 8;
  localparam int AES_WORD = 32;
  localparam int AES_NB   = 128;

  localparam logic [7:0] RED_POLY = 8'h1B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
  endfunction

  // Inverse-matrix coefficients expressed as sums of b, 2b, 4b and 8b.
  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_inv_col_mult.sv
// Combinational InvMixColumns of a single column; byte 0 is the column MSB.
module inv_col_mult
  import inv_mix_columns_seq_pkg::*;
#(
  parameter int BYTE = AES_BYTE,
  parameter int WORD = AES_WORD
) (
  input  logic [WORD-1:0] col_i,
  output logic [WORD-1:0] col_o
);

  logic [BYTE-1:0] s0, s1, s2, s3;

  assign s0 = col_i[WORD-1          -: BYTE];
  assign s1 = col_i[WORD-1-BYTE     -: BYTE];
  assign s2 = col_i[WORD-1-2*BYTE   -: BYTE];
  assign s3 = col_i[WORD-1-3*BYTE   -: BYTE];

  assign col_o = {mul14(s0) ^ mul11(s1) ^ mul13(s2) ^ mul9(s3),
                  mul9(s0)  ^ mul14(s1) ^ mul11(s2) ^ mul13(s3),
                  mul13(s0) ^ mul9(s1)  ^ mul14(s2) ^ mul11(s3),
                  mul11(s0) ^ mul13(s1) ^ mul9(s2)  ^ mul14(s3)};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: one column per cycle through a single shared
// column multiplier, valid/ready handshake on both sides.
module inv_mix_columns_seq
  import inv_mix_columns_seq_pkg::*;
#(
  parameter int BYTE = AES_BYTE,
  parameter int WORD = AES_WORD,
  parameter int Nb   = AES_NB
) (
  input  logic          Clk,
  input  logic          Reset_N,
  input  logic          In_Valid,
  output logic          In_Ready,
  input  logic [Nb-1:0] In_State,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic [Nb-1:0] Out_State
);

  logic [1:0]      fsm_q, fsm_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [Nb-1:0]   state_q, state_d;
  logic [Nb-1:0]   out_state_q, out_state_d;
  logic [WORD-1:0] col_in, col_out;

  inv_col_mult #(.BYTE(BYTE), .WORD(WORD)) u_col (
    .col_i(col_in),
    .col_o(col_out)
  );

  always_comb begin
    col_in = state_q[Nb-1 -: WORD];
    unique case (cnt_q)
      2'd0: col_in = state_q[Nb-1          -: WORD];
      2'd1: col_in = state_q[Nb-1-WORD     -: WORD];
      2'd2: col_in = state_q[Nb-1-2*WORD   -: WORD];
      2'd3: col_in = state_q[Nb-1-3*WORD   -: WORD];
      default: col_in = state_q[Nb-1 -: WORD];
    endcase
  end

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    out_state_d = out_state_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (In_Valid) begin
          state_d = In_State;
          cnt_d   = 2'd0;
          fsm_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        unique case (cnt_q)
          2'd0: state_d[Nb-1          -: WORD] = col_out;
          2'd1: state_d[Nb-1-WORD     -: WORD] = col_out;
          2'd2: state_d[Nb-1-2*WORD   -: WORD] = col_out;
          2'd3: state_d[Nb-1-3*WORD   -: WORD] = col_out;
          default: state_d = state_q;
        endcase
        cnt_d = cnt_q + 2'd1;
        // Result is published only once complete, so Out_State never shows a partial state.
        if (cnt_q == 2'd3) begin
          out_state_d = state_d;
          fsm_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (Out_Ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      fsm_q       <= ST_IDLE;
      cnt_q       <= 2'd0;
      state_q     <= '0;
      out_state_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      out_state_q <= out_state_d;
    end
  end

  assign In_Ready  = (fsm_q == ST_IDLE);
  assign Out_Valid = (fsm_q == ST_DONE);
  assign Out_State = out_state_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed and round-trip bench for inv_mix_columns_seq.
module tb_inv_mix_columns_seq;

  logic         Clk = 1'b0;
  logic         Reset_N, In_Valid, In_Ready, Out_Valid, Out_Ready;
  logic [127:0] In_State, Out_State;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 Clk = ~Clk;

  inv_mix_columns_seq dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_State(In_State),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_State(Out_State)
  );

  typedef struct {
    logic [127:0] st_in;
    logic [127:0] st_exp;
  } vec_t;

  // Forward MixColumns reference for the round-trip check.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ((b << 1) ^ 8'h1B) : (b << 1);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  task automatic chk(input int id, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL check %0d: got %h want %h", id, act, exp);
    end
  endtask

  // Offer a state, wait for acceptance and Out_Valid, capture and drain.
  task automatic run_txn(input logic [127:0] st, output logic [127:0] res, output int lat);
    int w;
    In_State = st;
    In_Valid = 1'b1;
    w = 0;
    while (!In_Ready && w < 20) begin
      @(posedge Clk); #1; w++;
    end
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    lat = 0;
    while (!Out_Valid && lat < 20) begin
      @(posedge Clk); #1; lat++;
    end
    res = Out_State;
    Out_Ready = 1'b1;
    @(posedge Clk); #1;
    Out_Ready = 1'b0;
  endtask

  initial begin
    vec_t         vecs[5];
    logic [127:0] res, last, rnd;
    int           lat;

    vecs[0] = '{128'h8e4da1bc_9fdc589d_c6c6c6c6_01010101, 128'hdb135345_f20a225c_c6c6c6c6_01010101};
    vecs[1] = '{128'hc6c6c6c6_01010101_d5d5d7d6_4d7ebdf8, 128'hc6c6c6c6_01010101_d4d4d4d5_2d26314c};
    vecs[2] = '{128'h0, 128'h0};
    vecs[3] = '{{128{1'b1}}, {128{1'b1}}};
    vecs[4] = '{128'h9fdc589d_4d7ebdf8_8e4da1bc_d5d5d7d6, 128'hf20a225c_2d26314c_db135345_d4d4d4d5};

    Reset_N = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0; In_State = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk(1, {127'b0, Out_Valid}, 128'd0);
    chk(2, Out_State, 128'd0);
    Reset_N = 1'b1;
    chk(3, {127'b0, In_Ready}, 128'd1);
    @(posedge Clk); #1;
    chk(4, {127'b0, In_Ready}, 128'd1);

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].st_in, res, lat);
      chk(10 + i, res, vecs[i].st_exp);
      chk(20 + i, 128'(lat), 128'd4);
    end

    // Backpressure: hold Out_Ready low, offer a competing input.
    In_State = vecs[0].st_in; In_Valid = 1'b1;
    @(posedge Clk); #1;
    In_State = vecs[4].st_in;
    lat = 0;
    while (!Out_Valid && lat < 20) begin
      @(posedge Clk); #1; lat++;
    end
    chk(30, 128'(lat), 128'd4);
    for (int k = 0; k < 10; k++) begin
      chk(31, {127'b0, Out_Valid}, 128'd1);
      chk(32, Out_State, vecs[0].st_exp);
      chk(33, {127'b0, In_Ready}, 128'd0);
      @(posedge Clk); #1;
    end
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    @(posedge Clk); #1;
    Out_Ready = 1'b0;
    chk(34, {127'b0, Out_Valid}, 128'd0);
    chk(35, {127'b0, In_Ready}, 128'd1);
    chk(36, Out_State, vecs[0].st_exp);

    // Abort on the second BUSY cycle.
    last = Out_State;
    In_State = vecs[1].st_in; In_Valid = 1'b1;
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    chk(40, {127'b0, In_Ready}, 128'd0);
    @(posedge Clk); #1;
    chk(41, Out_State, last);
    Reset_N = 1'b0;
    @(posedge Clk); #1;
    chk(42, {127'b0, Out_Valid}, 128'd0);
    chk(43, {127'b0, In_Ready}, 128'd1);
    chk(44, Out_State, 128'd0);
    Reset_N = 1'b1;
    chk(45, {127'b0, In_Ready}, 128'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk); #1;
      chk(46, {127'b0, Out_Valid}, 128'd0);
    end
    run_txn(vecs[1].st_in, res, lat);
    chk(47, res, vecs[1].st_exp);

    for (int n = 0; n < 1000; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_txn(mix_state(rnd), res, lat);
      chk(100, res, rnd);
      if (lat != 4) chk(101, 128'(lat), 128'd4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
